// File: rtl/isqrt_bsearch_seq.sv
`default_nettype none
//==============================================================================
// Module      : isqrt_bsearch_seq
// Description : Sequential integer square root by binary search over the root
//               range 0 .. 2^OUT_W-1. One operation in flight, start/done
//               handshake, floor or ceil result per operation, remainder
//               (always relative to the floor root) and exact flag.
// Ports       : clk        - rising-edge clock
//               rst        - synchronous active-high reset
//               start      - request, accepted only while busy == 0
//               n_in       - radicand, sampled on the accepting edge
//               ceil_mode  - sampled with n_in; 1 = ceil(sqrt), 0 = floor(sqrt)
//               busy       - high from the cycle after accept through done
//               done       - one-cycle pulse; root/rem/exact valid from here
//               root       - floor or ceil root (OUT_W+1 bits)
//               rem        - n - floor_root^2
//               exact      - rem == 0
// Revision    : 1.0 - initial release
//==============================================================================
module isqrt_bsearch_seq #(
    parameter int IN_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [IN_W-1:0]           n_in,
    input  logic                      ceil_mode,
    output logic                      busy,
    output logic                      done,
    output logic [(IN_W+1)/2:0]       root,
    output logic [IN_W-1:0]           rem,
    output logic                      exact
);

    localparam int OUT_W  = (IN_W + 1) / 2;
    localparam int SQ_W   = 2 * OUT_W;
    localparam int ITER_W = $clog2(OUT_W + 1);
    localparam logic [ITER_W-1:0] C_LAST_ITER = ITER_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ   = 3'd1,
        S_CMP  = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched operands
    logic [IN_W-1:0]   r_n;
    logic              r_ceil;

    // Search state
    logic [OUT_W-1:0]  r_lo;
    logic [OUT_W-1:0]  r_hi;
    logic [OUT_W-1:0]  r_mid;
    logic [SQ_W-1:0]   r_sq;
    logic [ITER_W-1:0] r_iter;

    // Registered outputs
    logic              r_busy;
    logic              r_done;
    logic [OUT_W:0]    r_root;
    logic [IN_W-1:0]   r_rem;
    logic              r_exact;

    // Datapath
    logic [OUT_W:0]    w_sum;
    logic              w_unused_sum_lsb;
    logic [OUT_W-1:0]  w_mid;
    logic [SQ_W-1:0]   w_mid_ext;
    logic [SQ_W-1:0]   w_mid_sq;
    logic [SQ_W-1:0]   w_n_ext;
    logic [SQ_W-1:0]   w_f_ext;
    logic [SQ_W-1:0]   w_f_sq;
    logic [SQ_W-1:0]   w_rem_full;
    logic              w_rem_zero;
    logic              w_accept;

    // The +1 biases mid upward so that lo=mid always makes progress; the sum
    // carries one extra bit so lo+hi+1 never wraps.
    assign w_sum            = {1'b0, r_lo} + {1'b0, r_hi} + (OUT_W+1)'(1);
    assign w_mid            = w_sum[OUT_W:1];
    assign w_unused_sum_lsb = w_sum[0];
    assign w_mid_ext        = {{OUT_W{1'b0}}, w_mid};
    assign w_mid_sq         = w_mid_ext * w_mid_ext;

    // For odd IN_W the square is wider than n; compare zero-extended.
    assign w_n_ext    = SQ_W'(r_n);
    assign w_f_ext    = {{OUT_W{1'b0}}, r_lo};
    assign w_f_sq     = w_f_ext * w_f_ext;
    // lo^2 <= n after the search, so the difference fits in IN_W bits.
    assign w_rem_full = w_n_ext - w_f_sq;
    assign w_rem_zero = (w_rem_full == '0);

    assign w_accept = (r_state == S_IDLE) && start;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SQ;
                end
            end
            S_SQ: begin
                w_next = S_CMP;
            end
            S_CMP: begin
                // The range starts at 2^OUT_W values and halves each pass.
                if (r_iter == C_LAST_ITER) begin
                    w_next = S_FIN;
                end else begin
                    w_next = S_SQ;
                end
            end
            S_FIN: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and output registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_ceil  <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_mid   <= '0;
            r_sq    <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_root  <= '0;
            r_rem   <= '0;
            r_exact <= 1'b0;
        end else begin
            // busy/done are registered images of the upcoming state
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n    <= n_in;
                        r_ceil <= ceil_mode;
                        r_lo   <= '0;
                        r_hi   <= '1;
                        r_iter <= '0;
                    end
                end
                S_SQ: begin
                    r_mid <= w_mid;
                    r_sq  <= w_mid_sq;
                end
                S_CMP: begin
                    if (r_sq <= w_n_ext) begin
                        r_lo <= r_mid;
                    end else begin
                        r_hi <= r_mid - OUT_W'(1);
                    end
                    r_iter <= r_iter + ITER_W'(1);
                end
                S_FIN: begin
                    r_rem   <= w_rem_full[IN_W-1:0];
                    r_exact <= w_rem_zero;
                    if (r_ceil && !w_rem_zero) begin
                        r_root <= {1'b0, r_lo} + (OUT_W+1)'(1);
                    end else begin
                        r_root <= {1'b0, r_lo};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign root  = r_root;
    assign rem   = r_rem;
    assign exact = r_exact;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_bsearch_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_isqrt_bsearch_seq
// Description : Self-checking bench for isqrt_bsearch_seq. Two instances:
//               IN_W=16 for directed cases and IN_W=9 for a random sweep.
//               Expected values come from a plain-arithmetic square root model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_isqrt_bsearch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // IN_W = 16 instance
    logic        rst16, start16, cm16;
    logic [15:0] n16;
    logic        busy16, done16, ex16;
    logic [8:0]  root16;
    logic [15:0] rem16;

    // IN_W = 9 instance
    logic        rst9, start9, cm9;
    logic [8:0]  n9;
    logic        busy9, done9, ex9;
    logic [5:0]  root9;
    logic [8:0]  rem9;

    int total = 0;
    int bad   = 0;

    isqrt_bsearch_seq #(.IN_W(16)) u_dut16 (
        .clk(clk), .rst(rst16), .start(start16), .n_in(n16), .ceil_mode(cm16),
        .busy(busy16), .done(done16), .root(root16), .rem(rem16), .exact(ex16)
    );

    isqrt_bsearch_seq #(.IN_W(9)) u_dut9 (
        .clk(clk), .rst(rst9), .start(start9), .n_in(n9), .ceil_mode(cm9),
        .busy(busy9), .done(done9), .root(root9), .rem(rem9), .exact(ex9)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: largest r with r*r <= n
    function automatic longint fsqrt(input longint n);
        longint r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Issue one operation on the 16-bit instance and wait for done.
    // lat is the cycle index of done, counting the accept edge as cycle 0.
    task automatic op16(input logic [15:0] n, input logic cm, output int lat);
        @(negedge clk);
        n16 = n; cm16 = cm; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 1;
        chk("busy16_after_accept", {63'd0, busy16}, 64'd1);
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] n, input logic cm);
        int     lat;
        longint f, r, er;
        f  = fsqrt(longint'(n));
        r  = longint'(n) - f * f;
        er = (cm && r != 0) ? f + 1 : f;
        op16(n, cm, lat);
        chk({tag, "_lat"},   64'(lat), 64'd18);
        chk({tag, "_root"},  {55'd0, root16}, 64'(er));
        chk({tag, "_rem"},   {48'd0, rem16},  64'(r));
        chk({tag, "_exact"}, {63'd0, ex16},   {63'd0, (r == 0)});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, done16}, 64'd0);
    endtask

    task automatic check9(input logic [8:0] n, input logic cm);
        int     lat;
        longint f, r, er, fd;
        f  = fsqrt(longint'(n));
        r  = longint'(n) - f * f;
        er = (cm && r != 0) ? f + 1 : f;
        @(negedge clk);
        n9 = n; cm9 = cm; start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        lat = 1;
        while (done9 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("w9_lat",   64'(lat), 64'd12);
        chk("w9_root",  {58'd0, root9}, 64'(er));
        chk("w9_rem",   {55'd0, rem9},  64'(r));
        chk("w9_exact", {63'd0, ex9},   {63'd0, (r == 0)});
        // Bracketing property on the floor root recovered from the outputs
        fd = longint'(root9) - ((cm && rem9 != 0) ? 1 : 0);
        chk("w9_bracket", {63'd0, (fd * fd <= longint'(n)) && (longint'(n) < (fd + 1) * (fd + 1))}, 64'd1);
    endtask

    initial begin
        int          cyc;
        int          lat;
        int          dq[$];
        logic [8:0]  droot[$];
        logic [15:0] drem[$];

        rst16 = 1'b1; start16 = 1'b0; cm16 = 1'b0; n16 = '0;
        rst9  = 1'b1; start9  = 1'b0; cm9  = 1'b0; n9  = '0;
        repeat (3) @(negedge clk);
        rst16 = 1'b0; rst9 = 1'b0;

        // Reset state
        chk("rst_busy",  {63'd0, busy16}, 64'd0);
        chk("rst_done",  {63'd0, done16}, 64'd0);
        chk("rst_root",  {55'd0, root16}, 64'd0);
        chk("rst_rem",   {48'd0, rem16},  64'd0);
        chk("rst_exact", {63'd0, ex16},   64'd0);
        chk("rst9_busy", {63'd0, busy9},  64'd0);

        // Directed 16-bit cases
        check16("n0_floor", 16'd0, 1'b0);
        check16("n0_ceil", 16'd0, 1'b1);
        check16("n144_ceil", 16'd144, 1'b1);
        check16("n200_floor", 16'd200, 1'b0);
        check16("n200_ceil", 16'd200, 1'b1);
        check16("nmax_floor", 16'hFFFF, 1'b0);
        chk("nmax_floor_const", {55'd0, root16}, 64'd255);
        check16("nmax_ceil", 16'hFFFF, 1'b1);
        chk("nmax_ceil_const", {55'd0, root16}, 64'd256);
        chk("nmax_ceil_rem", {48'd0, rem16}, 64'd510);
        chk("nmax_ceil_msb", {63'd0, root16[8]}, 64'd1);

        // Start while busy is ignored; start right after done is accepted
        @(negedge clk);
        n16 = 16'd50; cm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        while (cyc <= 40) begin
            start16 = (cyc == 5) || (cyc == 19);
            if (cyc == 5)  begin n16 = 16'd9;   cm16 = 1'b0; end
            if (cyc == 19) begin n16 = 16'd200; cm16 = 1'b0; end
            if (cyc == 20) begin
                chk("b2b_busy", {63'd0, busy16}, 64'd1);
                chk("hold_root", {55'd0, root16}, 64'd7);
            end
            if (done16 === 1'b1) begin
                dq.push_back(cyc);
                droot.push_back(root16);
                drem.push_back(rem16);
            end
            @(negedge clk);
            cyc++;
        end
        start16 = 1'b0;
        chk("busy_start_ndone", 64'(dq.size()), 64'd2);
        if (dq.size() == 2) begin
            chk("busy_start_cyc",  64'(dq[0]), 64'd18);
            chk("busy_start_root", {55'd0, droot[0]}, 64'd7);
            chk("busy_start_rem",  {48'd0, drem[0]},  64'd1);
            chk("b2b_cyc",  64'(dq[1]), 64'd37);
            chk("b2b_root", {55'd0, droot[1]}, 64'd14);
            chk("b2b_rem",  {48'd0, drem[1]},  64'd4);
        end

        // Reset in the middle of an operation
        @(negedge clk);
        n16 = 16'd1000; cm16 = 1'b1; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        chk("abort_busy",  {63'd0, busy16}, 64'd0);
        chk("abort_done",  {63'd0, done16}, 64'd0);
        chk("abort_root",  {55'd0, root16}, 64'd0);
        chk("abort_rem",   {48'd0, rem16},  64'd0);
        chk("abort_exact", {63'd0, ex16},   64'd0);
        lat = 0;
        repeat (30) begin
            @(negedge clk);
            if (done16 === 1'b1) lat++;
        end
        chk("abort_no_done", 64'(lat), 64'd0);
        check16("after_abort", 16'd1000, 1'b1);

        // Random 16-bit operations
        repeat (6) begin
            check16("rand16", 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end

        // IN_W = 9 sweep, including both range ends
        check9(9'd0, 1'b0);
        check9(9'd511, 1'b0);
        check9(9'd511, 1'b1);
        repeat (40) begin
            check9(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
